// File: rtl/spi_ram_master_arb.sv
// spi_ram_master_arb: two-port round-robin arbiter driving a serial RAM over a framed SPI link
//   clk, rst                           clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata, a_ack    port A request (held until ack) and completion pulse
//   b_req/b_we/b_addr/b_wdata, b_ack    port B equivalents
//   rdata                              last read result, updated as the read's ack is raised
//   busy                               operation in progress
//   SS_n, MOSI, MISO                   SPI slave select (active-low), serial out, serial in, MSB first
module spi_ram_master_arb #(
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_req,
   input  logic       a_we,
   input  logic [7:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic       a_ack,
   input  logic       b_req,
   input  logic       b_we,
   input  logic [7:0] b_addr,
   input  logic [7:0] b_wdata,
   output logic       b_ack,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, TURN, RECV, DONE} state_t;
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       frame_q, frame_d;
   logic [9:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rdata_q, rdata_d;
   logic       we_q, we_d;
   logic [7:0] wdata_q, wdata_d;
   // port being served (0 A, 1 B); kept after DONE so it doubles as the last-grant pointer
   logic       gnt_q, gnt_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         frame_q <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         gnt_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         gnt_q   <= gnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: if (a_req || b_req) begin
            gnt_d   = (a_req && b_req) ? ~gnt_q : b_req;
            we_d    = gnt_d ? b_we : a_we;
            wdata_d = gnt_d ? b_wdata : a_wdata;
            // frame 1 command: 00 write address, 10 read address
            tx_d    = {~we_d, 1'b0, gnt_d ? b_addr : a_addr};
            frame_d = 1'b0;
            state_d = SETUP;
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            tx_d  = {tx_q[8:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               cnt_d   = '0;
               state_d = !frame_q ? GAP : (we_q ? DONE : TURN);
            end
         end
         GAP: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == GAP_LAST) begin
               frame_d = 1'b1;
               tx_d    = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
               state_d = SETUP;
            end
         end
         TURN: begin
            cnt_d   = '0;
            state_d = RECV;
         end
         RECV: begin
            rx_d  = {rx_q[6:0], MISO};
            cnt_d = cnt_q + 4'd1;
            // capture the final bit directly so rdata is already valid during DONE
            if (cnt_q == 4'd7) begin
               rdata_d = rx_d;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      SS_n  = !(state_q inside {SETUP, SHIFT, TURN, RECV});
      MOSI  = (state_q == SHIFT) && tx_q[9];
      a_ack = (state_q == DONE) && !gnt_q;
      b_ack = (state_q == DONE) && gnt_q;
      busy  = state_q != IDLE;
   end
   assign rdata = rdata_q;
endmodule

// File: doc/spi_ram_master_arb.md
SPI_RAM_MASTER_ARB -- requirements
Module: spi_ram_master_arb

Interface
REQ-001 Parameter GAP_CYCLES, default 1, SS_n-high cycles between the two frames of one operation; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a_req  input  1  port A operation request; held high until a_ack.
REQ-005 a_we  input  1  port A op type: 1 write, 0 read.
REQ-006 a_addr  input  8  port A RAM address.
REQ-007 a_wdata  input  8  port A write data.
REQ-008 a_ack  output  1  one-cycle completion pulse to port A.
REQ-009 b_req, b_we, b_addr, b_wdata, b_ack: port B equivalents of REQ-004..REQ-008, same widths and directions.
REQ-010 rdata  output  8  read result; valid in the ack cycle of a read, held until the next read completes.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 SS_n  output  1  SPI slave select, active-low.
REQ-013 MOSI  output  1  serial data to the SPI/RAM slave, MSB first.
REQ-014 MISO  input  1  serial read data from the slave, MSB first.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT, GAP, TURN, RECV, DONE.
REQ-016 IDLE: SS_n=1, MOSI=0; requests sampled only here; any request -> SETUP of frame 1 next cycle.
REQ-017 Arbitration round-robin: both requesting -> grant the port not granted last; last-grant pointer resets to B, so A wins first tie.
REQ-018 Granted port's we/addr/wdata SHALL be latched at the grant edge; later changes to that port's inputs are ignored until DONE.
REQ-019 Frame: SETUP 1 cycle (SS_n=0, MOSI=0), then SHIFT 10 cycles driving {cmd[1:0], payload[7:0]} MSB first, SS_n=0 throughout.
REQ-020 Write op: frame 1 cmd=00 payload=addr; GAP; frame 2 cmd=01 payload=wdata; DONE.
REQ-021 Read op: frame 1 cmd=10 payload=addr; GAP; frame 2 cmd=11 payload=0x00; TURN 1 cycle; RECV 8 cycles; DONE.
REQ-022 GAP: SS_n=1, MOSI=0 for exactly GAP_CYCLES cycles.
REQ-023 TURN/RECV: SS_n=0, MOSI=0; MISO sampled at the rising edge ending each RECV cycle into a shift register, bit 7 first.
REQ-024 Timing from grant edge E0 (cycle n = n-th cycle after E0), G=GAP_CYCLES: frame 1 cycles 1..11; gap 12..11+G; frame 2 cycles 12+G..22+G; write DONE at 23+G; read TURN 23+G, RECV 24+G..31+G, DONE 32+G.
REQ-025 DONE: SS_n=1, MOSI=0, granted port's ack=1 for exactly 1 cycle, rdata updated from shift register on reads (unchanged on writes); next state IDLE.
REQ-026 Back-to-back: at least one IDLE cycle between DONE and next SETUP; SS_n high for at least 2 cycles (DONE+IDLE) between operations.
REQ-027 Requester deasserting req mid-operation SHALL NOT abort it; operation completes and ack still pulses.
REQ-028 a_ack and b_ack SHALL never be high in the same cycle; a non-granted port's request is held pending, never dropped.

Reset
REQ-029 rst high at a rising edge, in any state including mid-frame: state=IDLE, SS_n=1, MOSI=0, a_ack=b_ack=0, rdata=0x00, busy=0, pointer=B, shift/counters cleared.
REQ-030 An operation interrupted by reset SHALL produce no ack; requests still high after rst falls are re-arbitrated from IDLE.

Verification
REQ-031 Write A, addr=0x3C, wdata=0xA5, G=1 -> MOSI frame 1 = 00_00111100, frame 2 = 01_10100101; a_ack single pulse at cycle 24.
REQ-032 Read B, addr=0x10, slave model returns 0x5A on MISO -> frames 10_00010000 then 11_00000000; b_ack and rdata=0x5A at cycle 33.
REQ-033 a_req and b_req raised same cycle after reset, both held -> A served first, B next; B's SETUP exactly 2 cycles after a_ack cycle.
REQ-034 A continuously requesting, B requesting -> grants alternate A,B,A,B over 4 operations.
REQ-035 rst pulsed at cycle 15 of a read -> SS_n=1 next cycle, no ack, rdata=0x00; reissued read completes normally.
REQ-036 GAP_CYCLES=4, write -> SS_n high exactly 4 cycles between frames; ack at cycle 27.
